// File: rtl/oled_spi_sink_if.sv
`default_nettype none
// ============================================================================
// Module      : oled_spi_sink_if
// Description : Pin bundle between an OLED controller and the panel model.
//               The controller side drives cs/sclk/sdin/dc/res. The panel
//               side drives the framebuffer write port, decoded state,
//               received-byte monitor and error pulse.
//               The master modport is the controller/bench side. The slave
//               modport is the panel model.
// Revision    : 1.0 - initial release
// ============================================================================
interface oled_spi_sink_if;
    // Controller -> panel pins
    logic        cs;          // chip select, active low
    logic        sclk;        // SPI clock, idles high
    logic        sdin;        // serial data, MSB first
    logic        dc;          // 0 = command, 1 = data
    logic        res;         // panel reset, active low
    // Panel -> framebuffer / observer
    logic        pix_we;
    logic [12:0] pix_addr;
    logic [7:0]  pix_data;
    logic        display_on;
    logic [7:0]  remap;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_dc;
    logic        err;

    modport master (
        output cs, sclk, sdin, dc, res,
        input  pix_we, pix_addr, pix_data, display_on, remap,
        input  byte_valid, byte_data, byte_dc, err
    );

    modport slave (
        input  cs, sclk, sdin, dc, res,
        output pix_we, pix_addr, pix_data, display_on, remap,
        output byte_valid, byte_data, byte_dc, err
    );
endinterface
`default_nettype wire

// File: rtl/oled_spi_sink.sv
`default_nettype none
// ============================================================================
// Module      : oled_spi_sink
// Description : SPI-slave model of a 96x64 SSD1331-style OLED panel.
//               Receives mode-3 MSB-first bytes and decodes the commands
//               AF/AE/A0/A1/A2/15/75. It writes dc=1 pixel bytes in
//               256-colour mode into an external framebuffer.
// Ports       : clk   - system clock
//               reset - asynchronous active-high reset
//               bus   - oled_spi_sink_if.slave. Inputs are cs/sclk/sdin/
//                       dc/res. Outputs are pix_we/pix_addr/pix_data,
//                       display_on, remap, byte_valid/byte_data/byte_dc
//                       and err.
// Parameters  : WIDTH, HEIGHT - panel size; WIDTH*HEIGHT <= 8192
//               SYNC_STAGES   - synchroniser depth; minimum 2
// Revision    : 1.0 - initial release
// ============================================================================
module oled_spi_sink #(
    parameter int WIDTH       = 96,
    parameter int HEIGHT      = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    oled_spi_sink_if.slave   bus
);

    localparam logic [7:0]  C_COL_LAST = 8'(WIDTH - 1);
    localparam logic [7:0]  C_ROW_LAST = 8'(HEIGHT - 1);
    localparam logic [12:0] C_WIDTH13  = 13'(WIDTH);

    typedef enum logic [0:0] {
        CMD_IDLE = 1'b0,
        CMD_ARGS = 1'b1
    } state_t;

    // Input synchronisers: the newest sample is in bit 0, and the oldest is in the MSB.
    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, sdin_sync_q, dc_sync_q, res_sync_q;
    logic cs_s, sclk_s, sdin_s, dc_s, res_s, sclk_rise;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdin_s    = sdin_sync_q[SYNC_STAGES-1];
    assign dc_s      = dc_sync_q[SYNC_STAGES-1];
    assign res_s     = res_sync_q[SYNC_STAGES-1];

    logic sclk_prev_q;
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    // Deserialiser
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       byte_pend_q;   // byte loaded last cycle; byte_valid follows

    // Registered outputs
    logic        byte_valid_q, byte_dc_q, err_q, pix_we_q, display_on_q;
    logic [7:0]  byte_data_q, pix_data_q, remap_q;
    logic [12:0] pix_addr_q;

    // Decoder state
    state_t     state_q;
    logic [7:0] opcode_q, arg0_q;
    logic [1:0] args_left_q;
    logic [7:0] col_start_q, col_end_q, row_start_q, row_end_q, col_q, row_q;

    logic [12:0] cur_addr;
    assign cur_addr = 13'(row_q) * C_WIDTH13 + 13'(col_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync_q    <= '1;
            sclk_sync_q  <= '1;
            sdin_sync_q  <= '0;
            dc_sync_q    <= '0;
            res_sync_q   <= '1;
            sclk_prev_q  <= 1'b1;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_pend_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            byte_dc_q    <= 1'b0;
            err_q        <= 1'b0;
            pix_we_q     <= 1'b0;
            pix_addr_q   <= '0;
            pix_data_q   <= '0;
            display_on_q <= 1'b0;
            remap_q      <= 8'h40;
            state_q      <= CMD_IDLE;
            opcode_q     <= '0;
            arg0_q       <= '0;
            args_left_q  <= '0;
            col_start_q  <= '0;
            col_end_q    <= C_COL_LAST;
            row_start_q  <= '0;
            row_end_q    <= C_ROW_LAST;
            col_q        <= '0;
            row_q        <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.cs};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], bus.sdin};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0],   bus.dc};
            res_sync_q  <= {res_sync_q[SYNC_STAGES-2:0],  bus.res};
            sclk_prev_q <= sclk_s;

            // Single-cycle strobes default low
            byte_pend_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
            pix_we_q     <= 1'b0;

            if (!res_s) begin
                // Panel reset wins over any byte in flight or being decoded
                bit_cnt_q    <= '0;
                display_on_q <= 1'b0;
                remap_q      <= 8'h40;
                state_q      <= CMD_IDLE;
                opcode_q     <= '0;
                arg0_q       <= '0;
                args_left_q  <= '0;
                col_start_q  <= '0;
                col_end_q    <= C_COL_LAST;
                row_start_q  <= '0;
                row_end_q    <= C_ROW_LAST;
                col_q        <= '0;
                row_q        <= '0;
            end else begin
                // ---------------- bit capture ----------------
                if (cs_s) begin
                    if (bit_cnt_q != 3'd0) begin
                        err_q <= 1'b1;          // partial byte abandoned
                    end
                    bit_cnt_q <= '0;
                end else if (sclk_rise) begin
                    shift_q   <= {shift_q[5:0], sdin_s};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_data_q <= {shift_q, sdin_s};
                        byte_dc_q   <= dc_s;
                        byte_pend_q <= 1'b1;
                    end
                end
                byte_valid_q <= byte_pend_q;

                // ---------------- decoder ----------------
                if (byte_valid_q) begin
                    if (!byte_dc_q) begin
                        if (state_q == CMD_IDLE) begin
                            opcode_q <= byte_data_q;
                            case (byte_data_q)
                                8'hAF: display_on_q <= 1'b1;
                                8'hAE: display_on_q <= 1'b0;
                                8'hA0, 8'hA1, 8'hA2: begin
                                    args_left_q <= 2'd1;
                                    state_q     <= CMD_ARGS;
                                end
                                8'h15, 8'h75: begin
                                    args_left_q <= 2'd2;
                                    state_q     <= CMD_ARGS;
                                end
                                default: err_q <= 1'b1;
                            endcase
                        end else if (args_left_q == 2'd2) begin
                            arg0_q      <= byte_data_q;
                            args_left_q <= 2'd1;
                        end else begin
                            // Last argument: apply and return to idle
                            args_left_q <= 2'd0;
                            state_q     <= CMD_IDLE;
                            case (opcode_q)
                                8'hA0: remap_q <= byte_data_q;
                                8'h15: begin
                                    if (byte_data_q > C_COL_LAST || arg0_q > byte_data_q) begin
                                        err_q <= 1'b1;
                                    end else begin
                                        col_start_q <= arg0_q;
                                        col_end_q   <= byte_data_q;
                                        col_q       <= arg0_q;
                                    end
                                end
                                8'h75: begin
                                    if (byte_data_q > C_ROW_LAST || arg0_q > byte_data_q) begin
                                        err_q <= 1'b1;
                                    end else begin
                                        row_start_q <= arg0_q;
                                        row_end_q   <= byte_data_q;
                                        row_q       <= arg0_q;
                                    end
                                end
                                default: ;              // A1/A2 argument ignored
                            endcase
                        end
                    end else begin
                        // A data byte cuts off a pending command, then is
                        // handled as pixel data in the same cycle
                        if (state_q == CMD_ARGS) begin
                            err_q       <= 1'b1;
                            state_q     <= CMD_IDLE;
                            args_left_q <= 2'd0;
                        end
                        if (remap_q[7:6] == 2'b00) begin
                            pix_we_q   <= 1'b1;
                            pix_addr_q <= cur_addr;
                            pix_data_q <= byte_data_q;
                            if (col_q == col_end_q) begin
                                col_q <= col_start_q;
                                row_q <= (row_q == row_end_q) ? row_start_q : row_q + 8'd1;
                            end else begin
                                col_q <= col_q + 8'd1;
                            end
                        end else begin
                            err_q <= 1'b1;              // 65k-colour data unsupported
                        end
                    end
                end
            end
        end
    end

    assign bus.pix_we     = pix_we_q;
    assign bus.pix_addr   = pix_addr_q;
    assign bus.pix_data   = pix_data_q;
    assign bus.display_on = display_on_q;
    assign bus.remap      = remap_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_data  = byte_data_q;
    assign bus.byte_dc    = byte_dc_q;
    assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: doc/oled_spi_sink.md
Name: oled_spi_sink

Overview:
- SPI-slave model of the SSD1331-style 96x64 OLED panel; the receiving end of the OLED controller's cs/sclk/sdin/dc/res pins.
- Deserialises mode-3 (CPOL=1, CPHA=1) MSB-first bytes, decodes commands and dc=1 pixel data, and writes 8-bit pixels into an external framebuffer through a write port.
- Used as the panel model in system benches and as an on-FPGA loopback sink.

Parameters:
- WIDTH, 96: panel columns.
- HEIGHT, 64: panel rows.
- SYNC_STAGES, 2: flops in each input synchroniser; minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  chip select, active low.
- sclk  in  1  SPI clock, idles high.
- sdin  in  1  serial data (MOSI).
- dc  in  1  0 = command byte, 1 = data byte.
- res  in  1  panel reset, active low.
- pix_we  out  1  one-cycle framebuffer write strobe.
- pix_addr  out  13  row*WIDTH+col.
- pix_data  out  8  pixel value.
- display_on  out  1  panel-on state.
- remap  out  8  last A0 argument.
- byte_valid  out  1  one-cycle pulse per received byte.
- byte_data  out  8  received byte, held until the next byte.
- byte_dc  out  1  dc value captured with byte_data.
- err  out  1  one-cycle pulse on any protocol error.

Behaviour:
- Reset values: all outputs 0 except remap=8'h40. Internal state: col_start=0, col_end=WIDTH-1, row_start=0, row_end=HEIGHT-1, col=0, row=0, bit count=0, decoder in CMD_IDLE.
- Synchronisation: cs, sclk, sdin, dc and res each pass through SYNC_STAGES flops. A rising edge is detected on the synchronised sclk. sclk high and low times are each >= SYNC_STAGES+2 clk periods.
- Bit capture: on a synchronised sclk rise with synchronised cs=0, shift sdin into bit 0 of the shifter and increment the 3-bit count.
  - On the 8th bit, load byte_data and byte_dc (dc sampled at that same edge).
  - byte_valid pulses on the next cycle.
- cs high: clears the bit count immediately. If the count was nonzero, the partial byte is discarded and err pulses.
- res low (synchronised): returns all decoder state, display_on, remap, window and pointer to reset values. The bit count clears and no bytes are accepted. res takes priority over any byte completing in the same cycle.
- Decoder FSM, states CMD_IDLE and CMD_ARGS. Act on each byte_valid.
  - CMD_IDLE with dc=0, opcode to argument count:
    - AF: 0 args; display_on=1.
    - AE: 0 args; display_on=0.
    - A0: 1 arg; sets remap.
    - A1, A2: 1 arg each; consumed and ignored.
    - 15: 2 args (start, end); column window.
    - 75: 2 args (start, end); row window.
    - Any other opcode: 0 args; err pulses.
  - An opcode with args > 0 stores the opcode, loads the remaining-argument count and moves to CMD_ARGS.
  - CMD_ARGS with dc=0: the byte is the next argument. After the last argument, apply the command and return to CMD_IDLE.
  - 15/75 apply: if end > limit-1 or start > end, the window is unchanged and err pulses. Otherwise the window is updated and col (or row) is set to the new start.
  - dc=1 in CMD_ARGS: the pending command is discarded, err pulses, the FSM returns to CMD_IDLE and the byte is processed as data in the same cycle.
- Data bytes (dc=1):
  - If remap[7:6]==2'b00 (256-colour mode): pix_we=1, pix_addr=row*WIDTH+col, pix_data=byte, all in the cycle after byte_valid.
  - Otherwise the byte is dropped and err pulses.
  - Pointer after each write: if col==col_end, col=col_start and row advances; otherwise col+1.
  - Row advance: if row==row_end, row=row_start; otherwise row+1. A full window wraps to its origin.
- Latency from the raw sclk rise of bit 0 (8th bit) to pix_we: SYNC_STAGES+3 clk cycles, fixed.
- display_on does not gate pixel writes.
- pix_addr width is fixed at 13 bits; WIDTH*HEIGHT must be <= 8192.

Test Plan:
- Power-up: reset, then bytes AF, A0, 20 with dc=0 -> display_on=1, remap=8'h20, three byte_valid pulses, err never asserted.
- Pixel stream: 256-colour mode, 15 00 5F, 75 00 3F, then 6144 data bytes counting 0..255 -> pix_addr 0..6143 in order, pix_data=addr[7:0], pointer back at (0,0).
- Window wrap: 15 02 04, 75 01 02, then 7 data bytes -> pix_addr 98,99,100,194,195,196,98.
- Bad window: 15 05 02 -> err pulse, window and pointer unchanged; 15 00 60 -> err pulse.
- Abort and errors: 15 03 then a dc=1 byte 8'hAA -> err pulse, write of AA at the prior pointer. cs raised after 5 bits -> err pulse, no byte_valid. Opcode 8'hBB -> err pulse.
- Reset mid-operation: res low during the second argument of 75 -> state back to defaults, remap=8'h40, subsequent data byte -> err pulse (65k mode), no pix_we.
